// File: rtl/data_ram_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_resp_pkg
// Shared constants and types for the data-memory responder:
//   - reset / chip-enable / write-enable polarities and the zero word
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - lane write-enable helper used when committing a write
// -----------------------------------------------------------------------------
package data_ram_resp_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam int          REG_BUS      = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Per-lane write strobes: only a committed write drives any lane.
  function automatic logic [3:0] lane_write_enables(input logic access,
                                                    input logic we,
                                                    input logic [3:0] sel);
    lane_write_enables = (access && (we == WRITE_ENABLE)) ? sel : 4'b0000;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// -----------------------------------------------------------------------------
// data_ram_bank
// Four 8-bit storage arrays, one per byte lane, with per-lane synchronous write
// and a registered full-word read. Lane i holds word bits [8i+7:8i], so lane 3
// is the big-endian byte at offset 0.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset of the read register only
//   lane_we  per-lane write strobes
//   re       read strobe (captures the addressed word into rdata)
//   addr     word index
//   wdata    write data word
//   rdata    registered read data word
// -----------------------------------------------------------------------------
module data_ram_bank
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            lane_we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_r;

    // Lane storage write; array contents survive reset.
    always_ff @(posedge clk) begin
      if (lane_we[i]) begin
        mem_r[addr] <= wdata[8*i +: 8];
      end
    end

    // Lane read register; holds its value until the next read.
    always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
        rd_r <= 8'h00;
      end else if (re) begin
        rd_r <= mem_r[addr];
      end
    end

    assign rdata[8*i +: 8] = rd_r;
  end

endmodule

// File: rtl/data_ram_resp.sv
// -----------------------------------------------------------------------------
// data_ram_resp
// Responder for the memory-stage data interface. Accepts a request in IDLE,
// burns WAIT_STATES cycles in BUSY, performs the array access on the last BUSY
// edge and reports completion in DONE. The pipeline is stalled until DONE.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   ce          chip enable (request valid; dropping it in BUSY aborts)
//   we          1 = write, 0 = read
//   addr        byte address; bits [ADDR_WIDTH+1:2] select the word
//   sel         byte-lane enables, sel[3] = data[31:24]
//   data_i      write data
//   data_o      registered read data word
//   stallreq_o  stall request while an access is outstanding
// -----------------------------------------------------------------------------
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [3:0]         sel,
  input  logic [REG_BUS-1:0] data_i,
  output logic [REG_BUS-1:0] data_o,
  output logic               stallreq_o
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e                state_r;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic [3:0]            sel_r;
  logic [31:0]           wdata_r;
  logic [ADDR_WIDTH-1:0] idx_r;

  logic                  access_s;
  logic                  read_s;
  logic [3:0]            lane_we_s;
  logic                  stall_s;
  logic                  unused_addr_s;

  // Byte offset and bits above the array depth do not take part in decode.
  assign unused_addr_s = &{1'b0, addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Access fires on the last BUSY edge unless aborted or reset on that edge.
  always_comb begin
    access_s = 1'b0;
    if ((state_r == BUSY) && (ce == CHIP_ENABLE) && (cnt_r == 4'd0) &&
        (rst != RST_ENABLE)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
  end

  assign lane_we_s = lane_write_enables(access_s, we_r, sel_r);
  assign read_s    = access_s && (we_r != WRITE_ENABLE);

  // Stall request: follows ce in IDLE so the pipeline stalls in the request cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = ce;
      BUSY:    stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign stallreq_o = stall_s;

  // Request latch, wait counter and state sequencing.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'b0000;
      wdata_r <= ZERO_WORD;
      idx_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ce == CHIP_ENABLE) begin
            we_r    <= we;
            sel_r   <= sel;
            wdata_r <= data_i;
            idx_r   <= addr[ADDR_WIDTH+1:2];
            cnt_r   <= WAIT_CNT;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (ce != CHIP_ENABLE) begin
            state_r <= IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= DONE;
          end
        end
        // The request is still on the bus this cycle, so never re-accept here.
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  data_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .lane_we(lane_we_s),
    .re     (read_s),
    .addr   (idx_r),
    .wdata  (wdata_r),
    .rdata  (data_o)
  );

endmodule

// File: tb/tb_data_ram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_ram_resp
// Three responders (WAIT_STATES = 1, 0, 3) share clock and reset. Directed
// vectors, abort and reset sequences run on the WAIT_STATES=1 instance; a
// preload plus randomized traffic runs on all three against a word-array model.
// -----------------------------------------------------------------------------
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_v  [3];
  logic        we_v  [3];
  logic [31:0] addr_v[3];
  logic [3:0]  sel_v [3];
  logic [31:0] di_v  [3];
  logic [31:0] do_v  [3];
  logic        st_v  [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    data_ram_resp #(
      .ADDR_WIDTH (10),
      .WAIT_STATES((k == 0) ? 1 : ((k == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce_v[k]),
      .we        (we_v[k]),
      .addr      (addr_v[k]),
      .sel       (sel_v[k]),
      .data_i    (di_v[k]),
      .data_o    (do_v[k]),
      .stallreq_o(st_v[k])
    );
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_m  [3][1024];
  logic [31:0] last_rd[3];
  int          last_start[3];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [11];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete handshake; returns one cycle after DONE with ce still high.
  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit chk_iv,
                      input string name);
    int st;
    bit done;
    int idx;
    ce_v[k]   = 1'b1;
    we_v[k]   = w;
    addr_v[k] = a;
    sel_v[k]  = s;
    di_v[k]   = d;
    if (chk_iv) chk({name, " interval"}, 32'(cyc - last_start[k]), 32'(ws_of(k) + 3));
    last_start[k] = cyc;
    st   = 0;
    done = 1'b0;
    while (!done && st < 40) begin
      @(negedge clk);
      if (!st_v[k]) begin
        done = 1'b1;
      end else begin
        st++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: stall still high after %0d cycles, expected %0d", name, st, ws_of(k) + 2);
    end else begin
      chk({name, " stall"}, 32'(st), 32'(ws_of(k) + 2));
      idx = int'((a >> 2) % 32'd1024);
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
        end
        chk({name, " data_o held"}, do_v[k], last_rd[k]);
      end else begin
        chk({name, " rdata"}, do_v[k], exp_rd);
        last_rd[k] = exp_rd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    ce_v[k] = 1'b0;
    we_v[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          word;
    logic        w;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 32'h0;
      sel_v[k] = 4'h0; di_v[k] = 32'h0;
      last_rd[k] = 32'h0; last_start[k] = 0;
    end

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0021, 4'b0100, 32'hAAAA_AAAA, 32'h0};
    tbl[4]  = '{1'b1, 32'h0000_0022, 4'b0011, 32'h5555_5555, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h11AA_5555};
    tbl[6]  = '{1'b1, 32'h0000_0030, 4'b1111, 32'h0000_0000, 32'h0};
    tbl[7]  = '{1'b1, 32'h0000_1004, 4'b1111, 32'h1234_5678, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0007, 4'b0000, 32'h0,         32'h1234_5678};
    tbl[9]  = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0010, 4'b1010, 32'h0,         32'hDEAD_BEEF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset data_o[%0d]", k), do_v[k], 32'h0);
      chk($sformatf("reset stall[%0d]", k), 32'(st_v[k]), 32'h0);
    end
    @(posedge clk);
    #1;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 11; i++) begin
      xact(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].e, (i > 0),
           $sformatf("vec%0d", i));
    end
    idle(0);

    // Abort: drop ce in the first BUSY cycle.
    ce_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h30;
    sel_v[0] = 4'b1111; di_v[0] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort stall idle", 32'(st_v[0]), 32'h1);
    @(posedge clk);
    #1;
    ce_v[0] = 1'b0;
    @(negedge clk);
    chk("abort stall busy", 32'(st_v[0]), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort stall after", 32'(st_v[0]), 32'h0);
    chk("abort data_o held", do_v[0], last_rd[0]);
    @(posedge clk);
    #1;
    xact(0, 1'b0, 32'h30, 4'b1111, 32'h0, 32'h0000_0000, 1'b0, "abort readback");
    idle(0);

    // Reset asserted on the access edge of a write.
    ce_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h10;
    sel_v[0] = 4'b1111; di_v[0] = 32'hBADB_ADBA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst stall", 32'(st_v[0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst data_o[%0d]", k), do_v[k], 32'h0);
      last_rd[k] = 32'h0;
    end
    @(posedge clk);
    #1;
    xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, "midrst readback");
    idle(0);

    // Preload a 16-word window, then random traffic against the model.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++) begin
        xact(k, 1'b1, 32'(j * 4), 4'b1111, $urandom, 32'h0, (j > 0),
             $sformatf("pre%0d_%0d", k, j));
      end
      for (int n = 0; n < 30; n++) begin
        w    = 1'($urandom_range(0, 1));
        word = int'($urandom_range(0, 15));
        a    = ($urandom & 32'hFFFF_F003) | 32'(word << 2);
        xact(k, w, a, 4'($urandom_range(0, 15)), $urandom, mem_m[k][word], 1'b1,
             $sformatf("rnd%0d_%0d", k, n));
      end
      idle(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Responder end of the memory-stage data-memory interface (ce/we/addr/sel/data).
- Holds word-organised, big-endian, byte-lane-writable data RAM.
- Inserts a configurable number of wait states and raises a pipeline stall request until each access completes.
- Read data returns as a full word; the memory stage performs lane extraction and sign/zero extension.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words.
- WAIT_STATES, 1, extra cycles spent in BUSY before the array access (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1)
- ce  in  1  chip enable from memory stage (`ChipEnable)
- we  in  1  1 = write, 0 = read (`WriteEnable)
- addr  in  32  byte address; bits [ADDR_WIDTH+1:2] index the word
- sel  in  4  byte-lane enables; sel[3] = data[31:24] = byte offset 0 (big-endian)
- data_i  in  32  write data, lanes pre-replicated by the memory stage
- data_o  out  32  read data word
- stallreq_o  out  1  request to stall the pipeline while an access is outstanding

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` synchronous, active-high.
- FSM states:
  - IDLE: stallreq_o = ce (combinational). If ce = 1, latch we/sel/data_i/word index, load cnt = WAIT_STATES, go BUSY. Otherwise stay.
  - BUSY: stallreq_o = 1. If ce = 0 (flush/abort), go IDLE with no write and data_o unchanged. Else if cnt != 0, decrement. Else perform the access this edge and go DONE.
  - DONE: stallreq_o = 0; data_o valid. Always return to IDLE. No re-accept here, because the pipeline still presents the same request this cycle.
- Access:
  - Write: for each i with latched sel[i] = 1, byte lane i of the word is written from latched data_i; other lanes keep their value. data_o is unchanged.
  - Read: full word registered into data_o at the access edge; sel is ignored for reads.
- Latency: request first seen at cycle T; access edge ends cycle T+1+WAIT_STATES; DONE is cycle T+2+WAIT_STATES. stallreq_o is high for exactly WAIT_STATES+2 cycles.
- Back-to-back requests: the minimum issue interval is WAIT_STATES+3 cycles (IDLE after DONE accepts the next request).
- Address handling:
  - addr[1:0] is ignored; lanes come only from sel.
  - Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo depth.
- sel = 4'b0000 with we = 1: the full handshake runs, no lane is written.
- Inputs changing during BUSY have no effect (latched at accept); only ce is monitored, for abort.
- Reset (any state, including mid-access): state IDLE, cnt = 0, data_o = `ZeroWord, stallreq_o = 0 (ce low). No pending write commits. RAM contents are not cleared.
- ce = 0 in IDLE: no state change; data_o holds its last value.

Decomposition:
- Shared define.v: `RstEnable, `ChipEnable/`ChipDisable, `WriteEnable/`WriteDisable, `ZeroWord, `RegBus, `DataAddrBus; localparam state encodings IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
- One sub-module: data_ram_bank — four 8-bit arrays with per-lane synchronous write enable and a synchronous full-word read. It contains no control logic.
- The FSM, wait counter and request latch stay in data_ram_resp.

Test Plan:
- Word write then read, WAIT_STATES=1:
  - ce=1, we=1, addr=0x0000_0010, sel=1111, data_i=0xDEADBEEF → stallreq_o high for 3 cycles.
  - Then read 0x10 → data_o=0xDEADBEEF in DONE; stallreq_o low in DONE.
- Byte-lane writes:
  - Preload 0x11223344 at 0x20.
  - sb to 0x21: sel=0100, data_i=0xAAAAAAAA; then sh to 0x22: sel=0011, data_i=0x5555_5555.
  - Read 0x20 → 0x11AA5555.
- Abort: start a write 0xCAFEF00D to 0x30 (prior value 0x0); drop ce in the first BUSY cycle → FSM back to IDLE next cycle, stallreq_o low. Read 0x30 → 0x00000000.
- Wrap/alignment, ADDR_WIDTH=10: write 0x12345678 to addr 0x0000_1004; read addr 0x0000_0007 → 0x12345678 (word 1, offset bits ignored).
- Reset mid-access: assert rst during BUSY of a write → next cycle state IDLE, data_o=0, no write committed. Subsequent read returns the prior word.
- WAIT_STATES=0 and 3 sweep: back-to-back reads → stallreq_o pulse length 2 and 5 cycles respectively; issue interval 3 and 6 cycles respectively.
